// File: rtl/stpu_imem_bridge_pkg.sv
// -----------------------------------------------------------------------------
// stpu_imem_bridge_pkg
// Shared constants for the stpu instruction-fetch bridge: default memory
// latency, response buffer depth, memory base address and the encoding of
// the per-response fault flag carried alongside each instruction word.
// -----------------------------------------------------------------------------
package stpu_imem_bridge_pkg;

    localparam int          STPU_IMEM_MEM_LAT    = 1;
    localparam int          STPU_IMEM_FIFO_DEPTH = 4;
    localparam logic [31:0] STPU_IMEM_BASE_ADDR  = 32'h0000_0000;

    // Fault flag stored as the MSB of every buffered response.
    typedef enum logic {
        STPU_IMEM_OK    = 1'b0,
        STPU_IMEM_FAULT = 1'b1
    } stpu_imem_status_e;

endpackage

// File: rtl/stpu_sync_fifo.sv
// -----------------------------------------------------------------------------
// stpu_sync_fifo
// First-word fall-through synchronous FIFO with a synchronous clear.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   i_clr    : synchronous clear (wins over push/pop)
//   i_push   : write i_wdata (accepted when not full, or full with a pop)
//   i_wdata  : write data
//   i_pop    : consume the head entry (ignored when empty)
//   o_rdata  : head entry, valid whenever o_empty = 0
//   o_full   : DEPTH entries stored
//   o_empty  : no entries stored
// -----------------------------------------------------------------------------
module stpu_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_cnt;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_rd    = i_pop & ~o_empty;
    assign w_wr    = i_push & (~o_full | w_rd);
    assign o_rdata = r_mem[r_rptr];

    // NOTE: storage has no reset; validity is tracked by r_cnt alone, so the
    // array can map onto plain RAM/register cells without reset wiring.
    always_ff @(posedge clk) begin
        if (w_wr && !i_clr) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + AW'(1);
            if (w_rd) r_rptr <= r_rptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/stpu_imem_bridge.sv
// -----------------------------------------------------------------------------
// stpu_imem_bridge
// Instruction-fetch bridge between the stpu core fetch port and a synchronous
// instruction memory with MEM_LAT cycles of read latency. Up to FIFO_DEPTH
// fetches may be outstanding; responses return in grant order through a
// fall-through buffer, faults (misaligned / out of range) are reported
// in-order, and flush_i discards everything in flight.
//   clk, rst         : clock; asynchronous active-low reset
//   fetch_req_i/addr : core fetch request and byte address
//   fetch_gnt_o      : request accepted this cycle
//   fetch_rvalid_o   : response available (rdata/fault held until rready)
//   fetch_rdata_o    : instruction, 0 on fault
//   fetch_fault_o    : response is a fault
//   fetch_rready_i   : core consumes the response
//   flush_i          : drop all in-flight and buffered fetches
//   mem_ce_o/addr_o  : memory read enable and word address
//   mem_rdata_i      : memory data, MEM_LAT cycles after mem_ce_o
// -----------------------------------------------------------------------------
module stpu_imem_bridge
    import stpu_imem_bridge_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                MEM_AW     = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(STPU_IMEM_BASE_ADDR),
    parameter int                MEM_LAT    = STPU_IMEM_MEM_LAT,
    parameter int                FIFO_DEPTH = STPU_IMEM_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_gnt_o,
    output logic              fetch_rvalid_o,
    output logic [DATA_W-1:0] fetch_rdata_o,
    output logic              fetch_fault_o,
    input  logic              fetch_rready_i,
    input  logic              flush_i,
    output logic              mem_ce_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int                DEPTH   = 2 ** MEM_AW;
    localparam int                CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic [ADDR_W-1:0]  w_off;
    stpu_imem_status_e  w_status;
    logic               w_gnt;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [DATA_W:0]    w_wdata;
    logic [DATA_W:0]    w_rdata;
    logic [MEM_LAT-1:0] r_vld;
    logic [MEM_LAT-1:0] r_flt;
    logic [CNT_W-1:0]   r_cnt;

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_off    = fetch_addr_i - BASE_ADDR;
        w_status = STPU_IMEM_OK;
        if ((fetch_addr_i[1:0] != 2'b00) || (fetch_addr_i < BASE_ADDR) ||
            ((w_off >> 2) >= DEPTH_A)) begin
            w_status = STPU_IMEM_FAULT;
        end
        // rst gates the grant so a held request cannot leak through in reset.
        w_gnt      = rst & fetch_req_i & ~flush_i & (r_cnt < CNT_W'(FIFO_DEPTH));
        mem_ce_o   = w_gnt & (w_status == STPU_IMEM_OK);
        mem_addr_o = '0;
        if (w_gnt) begin
            mem_addr_o = w_off[MEM_AW+1:2];
        end
    end

    assign fetch_gnt_o = w_gnt;

    // Latency pipeline: bit 0 is the cycle after the grant; the top bit lines
    // up with the cycle the memory returns data for that grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
            r_flt <= '0;
        end else if (flush_i) begin
            r_vld <= '0;
            r_flt <= '0;
        end else begin
            r_vld <= MEM_LAT'({r_vld, w_gnt});
            r_flt <= MEM_LAT'({r_flt, (w_status == STPU_IMEM_FAULT)});
        end
    end

    assign w_push  = r_vld[MEM_LAT-1] & ~flush_i;
    assign w_wdata = r_flt[MEM_LAT-1] ? {1'b1, {DATA_W{1'b0}}} : {1'b0, mem_rdata_i};
    assign w_pop   = ~w_empty & fetch_rready_i & ~flush_i;

    stpu_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (flush_i),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign fetch_rvalid_o = ~w_empty;
    assign fetch_rdata_o  = w_empty ? '0 : w_rdata[DATA_W-1:0];
    assign fetch_fault_o  = ~w_empty & w_rdata[DATA_W];

    // Outstanding count: in-flight plus buffered. Bounding grants by this
    // count guarantees the buffer always has room when data returns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (flush_i) begin
            r_cnt <= '0;
        end else begin
            case ({w_gnt, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(w_push && w_full && !w_pop))
                else $error("stpu_imem_bridge: response buffer overflow");
        end
    end

endmodule

// File: tb/tb_stpu_imem_bridge.sv
// -----------------------------------------------------------------------------
// tb_stpu_imem_bridge
// Self-checking bench: directed scenarios followed by random traffic, all
// checked against a transaction-level model (a queue of expected responses,
// each tagged with the cycle it becomes visible).
// -----------------------------------------------------------------------------
module tb_stpu_imem_bridge;

    localparam int          MEM_LAT = 2;
    localparam int          FD      = 4;
    localparam int          MEM_AW  = 4;
    localparam int          NW      = 16;
    localparam logic [31:0] BASE    = 32'h0000_0100;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_req_i;
    logic [31:0]       fetch_addr_i;
    logic              fetch_gnt_o;
    logic              fetch_rvalid_o;
    logic [31:0]       fetch_rdata_o;
    logic              fetch_fault_o;
    logic              fetch_rready_i;
    logic              flush_i;
    logic              mem_ce_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic [31:0]       mem_rdata_i;

    stpu_imem_bridge #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .MEM_AW     (MEM_AW),
        .BASE_ADDR  (BASE),
        .MEM_LAT    (MEM_LAT),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_req_i    (fetch_req_i),
        .fetch_addr_i   (fetch_addr_i),
        .fetch_gnt_o    (fetch_gnt_o),
        .fetch_rvalid_o (fetch_rvalid_o),
        .fetch_rdata_o  (fetch_rdata_o),
        .fetch_fault_o  (fetch_fault_o),
        .fetch_rready_i (fetch_rready_i),
        .flush_i        (flush_i),
        .mem_ce_o       (mem_ce_o),
        .mem_addr_o     (mem_addr_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data for a ce cycle appears MEM_LAT cycles later;
    // non-ce cycles return junk so ignored slots are really exercised.
    logic [31:0] mem   [NW];
    logic [31:0] mpipe [MEM_LAT];
    always @(posedge clk) begin
        mpipe[0] <= mem_ce_o ? mem[mem_addr_o] : $urandom;
        for (int i = 1; i < MEM_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mem_rdata_i = mpipe[MEM_LAT-1];

    typedef struct {
        logic        fault;
        logic [31:0] data;
        int          ready;
    } resp_t;

    resp_t q[$];
    int    cyc        = 0;
    int    vectors    = 0;
    int    miscompares = 0;
    logic  g_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic is_fault(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return (addr[1:0] != 2'b00) || (addr < BASE) || ((off >> 2) >= 32'(NW));
    endfunction

    // One clock cycle: drive inputs, check all outputs against the model,
    // advance the model, then cross the rising edge.
    task automatic step(input logic req, input logic [31:0] addr,
                        input logic rdy, input logic fl);
        logic        exp_gnt;
        logic        exp_rv;
        logic        f;
        logic [31:0] off;
        logic [3:0]  exp_ma;
        resp_t       e;
        fetch_req_i    = req;
        fetch_addr_i   = addr;
        fetch_rready_i = rdy;
        flush_i        = fl;
        #1;
        off = addr - BASE;
        f   = is_fault(addr);
        if (!rst) begin
            q.delete();
            check("rst_gnt",    32'(fetch_gnt_o),    32'd0);
            check("rst_ce",     32'(mem_ce_o),       32'd0);
            check("rst_maddr",  32'(mem_addr_o),     32'd0);
            check("rst_rvalid", 32'(fetch_rvalid_o), 32'd0);
            check("rst_rdata",  fetch_rdata_o,       32'd0);
            check("rst_fault",  32'(fetch_fault_o),  32'd0);
        end else begin
            exp_rv  = (q.size() > 0) && (q[0].ready <= cyc);
            exp_gnt = req && !fl && (q.size() < FD);
            exp_ma  = exp_gnt ? off[5:2] : 4'd0;
            check("gnt",    32'(fetch_gnt_o),    32'(exp_gnt));
            check("ce",     32'(mem_ce_o),       32'(exp_gnt && !f));
            check("maddr",  32'(mem_addr_o),     32'(exp_ma));
            check("rvalid", 32'(fetch_rvalid_o), 32'(exp_rv));
            if (exp_rv) begin
                check("rdata", fetch_rdata_o,       q[0].data);
                check("fault", 32'(fetch_fault_o),  32'(q[0].fault));
            end
            if (fl) begin
                q.delete();
            end else begin
                if (exp_rv && rdy) void'(q.pop_front());
                if (exp_gnt) begin
                    e.fault = f;
                    e.data  = f ? 32'd0 : mem[off[5:2]];
                    e.ready = cyc + MEM_LAT + 1;
                    q.push_back(e);
                end
            end
        end
        g_last = fetch_gnt_o;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    int          grants;
    int          r;
    logic [31:0] a;

    initial begin
        for (int i = 0; i < NW; i++) mem[i] = $urandom;
        for (int i = 0; i < MEM_LAT; i++) mpipe[i] = 32'hDEAD_BEEF;
        rst            = 1'b0;
        fetch_req_i    = 1'b0;
        fetch_addr_i   = '0;
        fetch_rready_i = 1'b0;
        flush_i        = 1'b0;
        @(posedge clk);
        #1;

        // Reset state, with a request held to confirm it is not granted.
        step(1'b1, BASE + 32'h8, 1'b1, 1'b0);
        step(1'b1, BASE + 32'h8, 1'b1, 1'b0);
        rst = 1'b1;

        // Single fetch, then drain.
        step(1'b1, BASE + 32'h8, 1'b1, 1'b0);
        repeat (4) step(1'b0, '0, 1'b1, 1'b0);

        // Back-to-back fetches at full rate.
        for (int i = 0; i < 5; i++) step(1'b1, BASE + 32'(4 * i), 1'b1, 1'b0);
        repeat (5) step(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: only FD grants while nothing is consumed.
        grants = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, BASE + 32'(4 * i), 1'b0, 1'b0);
            grants += int'(g_last);
        end
        check("bp_grants", 32'(grants), 32'(FD));
        for (int i = 0; i < 4; i++) step(1'b1, BASE + 32'(4 * (i + 8)), 1'b1, 1'b0);
        repeat (8) step(1'b0, '0, 1'b1, 1'b0);

        // Fault boundaries: misaligned, below base, one past end, last word.
        step(1'b1, 32'h0000_0102, 1'b1, 1'b0);
        step(1'b1, 32'h0000_00FC, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0140, 1'b1, 1'b0);
        step(1'b1, 32'h0000_013C, 1'b1, 1'b0);
        repeat (6) step(1'b0, '0, 1'b1, 1'b0);

        // Flush with the pipeline and buffer both occupied.
        for (int i = 0; i < 4; i++) step(1'b1, BASE + 32'(4 * i), 1'b0, 1'b0);
        step(1'b1, BASE + 32'h4, 1'b1, 1'b1);
        check("post_flush_rvalid", 32'(fetch_rvalid_o), 32'd0);
        step(1'b1, BASE + 32'h20, 1'b1, 1'b0);
        repeat (6) step(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset between edges while a response is waiting.
        for (int i = 0; i < 3; i++) step(1'b1, BASE + 32'(4 * i), 1'b0, 1'b0);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0);
        check("pre_rst_rvalid", 32'(fetch_rvalid_o), 32'd1);
        fetch_req_i  = 1'b1;
        fetch_addr_i = BASE + 32'h10;
        #1;
        rst = 1'b0;
        #1;
        check("arst_rvalid", 32'(fetch_rvalid_o), 32'd0);
        check("arst_gnt",    32'(fetch_gnt_o),    32'd0);
        check("arst_ce",     32'(mem_ce_o),       32'd0);
        q.delete();
        @(posedge clk);
        #1;
        cyc++;
        step(1'b1, BASE + 32'h10, 1'b1, 1'b0);
        rst = 1'b1;
        repeat (6) step(1'b0, '0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8)       a = BASE + 32'(4 * $urandom_range(0, NW - 1));
            else if (r == 8) a = BASE + 32'($urandom_range(0, 63));
            else             a = 32'($urandom_range(0, 32'h200));
            step(($urandom_range(0, 9) < 7), a, ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 99) < 3));
        end
        repeat (8) step(1'b0, '0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
